time_set_ctrl: RTL and testbench

//   Upstream control stage for the hour/minute/second timekeeping counters. Debounces three raw

---
 rtl/time_set_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 47 ++++
 rtl/time_set_ctrl.sv | 133 +++++++++++++
 tb/tb_time_set_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_set_pkg.sv
// rtl/time_set_pkg.sv - status/state encoding for the time-set control stage and display decode
package time_set_pkg;

  localparam logic [2:0] ST_RUN      = 3'd0;
  localparam logic [2:0] ST_SET_HOUR = 3'd1;
  localparam logic [2:0] ST_SET_MIN  = 3'd2;

  typedef enum logic [2:0] {
    S_RUN      = ST_RUN,
    S_SET_HOUR = ST_SET_HOUR,
    S_SET_MIN  = ST_SET_MIN
  } state_e;

  function automatic state_e next_mode_state(input state_e s);
    case (s)
      S_RUN:      return S_SET_HOUR;
      S_SET_HOUR: return S_SET_MIN;
      default:    return S_RUN;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF sync, counter debouncer and rising-edge press pulse for one button
module btn_debounce #(
  parameter logic [15:0] DEB_CYC = 16'd50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  logic        sync1_q;
  logic        sync2_q;
  logic        level_q;
  logic        press_q;
  logic [15:0] cnt_q;
  logic        flip;

  assign flip = (sync2_q != level_q) && (cnt_q == DEB_CYC - 16'd1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      // Press fires together with the rising flip so the consumer registers it one cycle later.
      press_q <= flip && !level_q;
      if (sync2_q == level_q) begin
        cnt_q <= 16'd0;
      end else if (flip) begin
        level_q <= sync2_q;
        cnt_q   <= 16'd0;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - RUN/SET_HOUR/SET_MIN control with blink; AUTO_REPEAT_EN adds hold-to-repeat
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter logic [15:0] DEB_CYC = 16'd50000,
  parameter int          BLINK_W = 14
`ifdef AUTO_REPEAT_EN
  ,
  parameter logic [23:0] HOLD_CYC   = 24'd500000,
  parameter logic [23:0] REPEAT_CYC = 24'd100000
`endif
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       btn_mode_i,
  input  logic       btn_up_i,
  input  logic       btn_down_i,
  output logic       run_en_o,
  output logic       hour_inc_o,
  output logic       hour_dec_o,
  output logic       min_inc_o,
  output logic       min_dec_o,
  output logic       sec_clr_o,
  output logic [2:0] status_o,
  output logic       blink_o
);

  localparam logic [BLINK_W:0] BLINK_ONE = {{BLINK_W{1'b0}}, 1'b1};

  logic mode_lvl, mode_p;
  logic up_lvl, up_p;
  logic dn_lvl, dn_p;
  logic unused_lvl;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_mode (
    .clk_i(clock_i), .rst_i(reset_i), .btn_i(btn_mode_i), .level_o(mode_lvl), .press_o(mode_p)
  );
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_up (
    .clk_i(clock_i), .rst_i(reset_i), .btn_i(btn_up_i), .level_o(up_lvl), .press_o(up_p)
  );
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_down (
    .clk_i(clock_i), .rst_i(reset_i), .btn_i(btn_down_i), .level_o(dn_lvl), .press_o(dn_p)
  );

  state_e           state_q, state_d;
  logic             run_en_q;
  logic             hour_inc_q, hour_dec_q, min_inc_q, min_dec_q, sec_clr_q;
  logic [BLINK_W:0] blink_cnt_q;
  logic             up_press, dn_press;
  logic             up_ev, dn_ev;

  always_comb begin
    state_d = state_q;
    if (mode_p) state_d = next_mode_state(state_q);
    up_press = up_p && !dn_p;
    dn_press = dn_p && !up_p;
  end

`ifdef AUTO_REPEAT_EN
  logic        rep_act_q, rep_dn_q, rep_ph_q;
  logic [23:0] rep_cnt_q;
  logic        rep_hold_ok, rep_fire, rep_start;

  // Repeat only while exactly the armed button stays held in the same set state.
  assign rep_hold_ok = rep_act_q && (up_lvl ^ dn_lvl) && (rep_dn_q ? dn_lvl : up_lvl) && !mode_p;
  assign rep_fire    = rep_hold_ok && (rep_cnt_q == (rep_ph_q ? REPEAT_CYC : HOLD_CYC) - 24'd1);
  assign rep_start   = (state_q != S_RUN) && !mode_p && (up_press || dn_press);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rep_act_q <= 1'b0;
      rep_dn_q  <= 1'b0;
      rep_ph_q  <= 1'b0;
      rep_cnt_q <= 24'd0;
    end else if (rep_start) begin
      rep_act_q <= 1'b1;
      rep_dn_q  <= dn_press;
      rep_ph_q  <= 1'b0;
      rep_cnt_q <= 24'd0;
    end else if (!rep_hold_ok) begin
      rep_act_q <= 1'b0;
      rep_cnt_q <= 24'd0;
    end else if (rep_fire) begin
      rep_ph_q  <= 1'b1;
      rep_cnt_q <= 24'd0;
    end else begin
      rep_cnt_q <= rep_cnt_q + 24'd1;
    end
  end

  assign up_ev      = up_press || (rep_fire && !rep_dn_q);
  assign dn_ev      = dn_press || (rep_fire && rep_dn_q);
  assign unused_lvl = mode_lvl;
`else
  assign up_ev      = up_press;
  assign dn_ev      = dn_press;
  assign unused_lvl = mode_lvl ^ up_lvl ^ dn_lvl;
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_RUN;
      run_en_q    <= 1'b1;
      hour_inc_q  <= 1'b0;
      hour_dec_q  <= 1'b0;
      min_inc_q   <= 1'b0;
      min_dec_q   <= 1'b0;
      sec_clr_q   <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      run_en_q   <= (state_d == S_RUN);
      // A mode press in the same cycle swallows any up/down adjustment.
      hour_inc_q <= !mode_p && (state_q == S_SET_HOUR) && up_ev;
      hour_dec_q <= !mode_p && (state_q == S_SET_HOUR) && dn_ev;
      min_inc_q  <= !mode_p && (state_q == S_SET_MIN) && up_ev;
      min_dec_q  <= !mode_p && (state_q == S_SET_MIN) && dn_ev;
      sec_clr_q  <= mode_p && (state_q == S_SET_MIN);
      if ((state_d != state_q) || (state_d == S_RUN)) blink_cnt_q <= '0;
      else                                             blink_cnt_q <= blink_cnt_q + BLINK_ONE;
    end
  end

  assign run_en_o   = run_en_q;
  assign hour_inc_o = hour_inc_q;
  assign hour_dec_o = hour_dec_q;
  assign min_inc_o  = min_inc_q;
  assign min_dec_o  = min_dec_q;
  assign sec_clr_o  = sec_clr_q;
  assign status_o   = state_q;
  assign blink_o    = blink_cnt_q[BLINK_W];

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - scoreboard bench for time_set_ctrl (DEB_CYC=4, BLINK_W=3, HOLD=20, REPEAT=5)
module tb_time_set_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 5;
  localparam logic [2:0] B_MODE = 3'b001;
  localparam logic [2:0] B_UP   = 3'b010;
  localparam logic [2:0] B_DN   = 3'b100;

  logic       clock_i, reset_i, btn_mode_i, btn_up_i, btn_down_i;
  logic       run_en_o, hour_inc_o, hour_dec_o, min_inc_o, min_dec_o, sec_clr_o, blink_o;
  logic [2:0] status_o;

  time_set_ctrl #(
    .DEB_CYC(16'd4), .BLINK_W(3)
`ifdef AUTO_REPEAT_EN
    , .HOLD_CYC(24'd20), .REPEAT_CYC(24'd5)
`endif
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i), .btn_mode_i(btn_mode_i), .btn_up_i(btn_up_i),
    .btn_down_i(btn_down_i), .run_en_o(run_en_o), .hour_inc_o(hour_inc_o), .hour_dec_o(hour_dec_o),
    .min_inc_o(min_inc_o), .min_dec_o(min_dec_o), .sec_clr_o(sec_clr_o), .status_o(status_o),
    .blink_o(blink_o)
  );

  typedef struct { int kind; int cyc; } ev_t;  // kind: 1 h+,2 h-,3 m+,4 m-,5 sclr,9 multi
  ev_t exp_q[$];
  ev_t obs_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  always @(posedge clock_i) cyc <= cyc + 1;

  always @(negedge clock_i) begin
    int n;
    n = int'(hour_inc_o) + int'(hour_dec_o) + int'(min_inc_o) + int'(min_dec_o) + int'(sec_clr_o);
    if (!reset_i && n > 0) begin
      if (n > 1)           obs_q.push_back('{9, cyc});
      else if (hour_inc_o) obs_q.push_back('{1, cyc});
      else if (hour_dec_o) obs_q.push_back('{2, cyc});
      else if (min_inc_o)  obs_q.push_back('{3, cyc});
      else if (min_dec_o)  obs_q.push_back('{4, cyc});
      else                 obs_q.push_back('{5, cyc});
    end
  end

  task automatic press(input logic [2:0] m, input int hold);
    @(negedge clock_i);
    {btn_down_i, btn_up_i, btn_mode_i} = m;
    repeat (hold) @(negedge clock_i);
    {btn_down_i, btn_up_i, btn_mode_i} = 3'b000;
    repeat (DEB + 8) @(negedge clock_i);
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    {btn_down_i, btn_up_i, btn_mode_i} = 3'b000;
    repeat (3) @(negedge clock_i);
    checks++;
    if (run_en_o !== 1'b1 || status_o !== 3'd0 || blink_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: run_en=%b status=%0d blink=%b, want 1 0 0", run_en_o, status_o, blink_o);
    end
    checks++;
    if ({hour_inc_o, hour_dec_o, min_inc_o, min_dec_o, sec_clr_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_pulses: got %b want 00000", {hour_inc_o, hour_dec_o, min_inc_o, min_dec_o, sec_clr_o});
    end
    reset_i = 1'b0;
    press(B_MODE, 6);
    checks++;
    if (status_o !== 3'd1) begin
      failures++;
      $display("FAIL reset_pre_set: status=%0d want 1", status_o);
    end
    @(negedge clock_i);
    btn_up_i = 1'b1;
    repeat (3) @(negedge clock_i);
    reset_i = 1'b1;
    #1;
    checks++;
    if (run_en_o !== 1'b1 || status_o !== 3'd0 || blink_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: run_en=%b status=%0d blink=%b, want 1 0 0", run_en_o, status_o, blink_o);
    end
    btn_up_i = 1'b0;
    repeat (2) @(negedge clock_i);
    reset_i = 1'b0;
    repeat (15) @(negedge clock_i);
    checks++;
    if (run_en_o !== 1'b1 || status_o !== 3'd0 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL reset_hold: run_en=%b status=%0d pulses=%0d, want 1 0 0", run_en_o, status_o, obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_glitch_latency;
    int lat, lat_run, blink14, blink15;
    lat = 0; lat_run = 1; blink14 = -1; blink15 = -1;
    for (int g = 0; g < 3; g++) begin
      @(negedge clock_i); btn_mode_i = 1'b1;
      repeat (2) @(negedge clock_i);
      @(negedge clock_i); btn_mode_i = 1'b0;
      repeat (2) @(negedge clock_i);
    end
    repeat (10) @(negedge clock_i);
    checks++;
    if (status_o !== 3'd0 || run_en_o !== 1'b1) begin
      failures++;
      $display("FAIL glitch: status=%0d run_en=%b, want 0 1", status_o, run_en_o);
    end
    @(negedge clock_i);
    btn_mode_i = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clock_i);
      #1;
      if (lat == 0 && status_o == 3'd1) begin lat = k; lat_run = run_en_o; end
      if (k == 14) blink14 = blink_o;
      if (k == 15) blink15 = blink_o;
      if (k == 10) btn_mode_i = 1'b0;
    end
    checks++;
    if (lat != 2 + DEB + 1) begin
      failures++;
      $display("FAIL mode_latency: got %0d cycles want %0d", lat, 2 + DEB + 1);
    end
    checks++;
    if (lat_run != 0) begin
      failures++;
      $display("FAIL mode_run_en: got %0d want 0", lat_run);
    end
    checks++;
    if (blink14 != 0 || blink15 != 1) begin
      failures++;
      $display("FAIL blink_phase: got %0d,%0d want 0,1", blink14, blink15);
    end
    repeat (DEB + 8) @(negedge clock_i);
  endtask

  task automatic test_set_hour;
    ev_t e, o;
    exp_q.push_back('{1, -1}); press(B_UP, 6);
    exp_q.push_back('{1, -1}); press(B_UP, 6);
    exp_q.push_back('{2, -1}); press(B_DN, 6);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      checks++;
      if (obs_q.size() == 0) begin
        e = exp_q.pop_front(); failures++;
        $display("FAIL hour_pulses: missing kind=%0d", e.kind);
      end else if (exp_q.size() == 0) begin
        o = obs_q.pop_front(); failures++;
        $display("FAIL hour_pulses: unexpected kind=%0d at cyc %0d", o.kind, o.cyc);
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o.kind !== e.kind) begin
          failures++;
          $display("FAIL hour_pulses: got kind=%0d want kind=%0d", o.kind, e.kind);
        end
      end
    end
  endtask

  task automatic test_set_min_exit;
    ev_t e, o;
    int found;
    found = 0;
    press(B_MODE, 6);
    checks++;
    if (status_o !== 3'd2 || run_en_o !== 1'b0) begin
      failures++;
      $display("FAIL enter_min: status=%0d run_en=%b want 2 0", status_o, run_en_o);
    end
    exp_q.push_back('{5, -1});
    @(negedge clock_i);
    btn_mode_i = 1'b1;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clock_i);
      if (status_o == 3'd0) begin
        found = 1;
        checks++;
        if (run_en_o !== 1'b1 || sec_clr_o !== 1'b1 || blink_o !== 1'b0) begin
          failures++;
          $display("FAIL exit_min: run_en=%b sec_clr=%b blink=%b want 1 1 0", run_en_o, sec_clr_o, blink_o);
        end
      end
    end
    checks++;
    if (found == 0) begin
      failures++;
      $display("FAIL exit_min_timeout: status=%0d want 0 within 20 cycles", status_o);
    end
    repeat (4) @(negedge clock_i);
    btn_mode_i = 1'b0;
    repeat (DEB + 8) @(negedge clock_i);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      checks++;
      if (obs_q.size() == 0) begin
        e = exp_q.pop_front(); failures++;
        $display("FAIL exit_pulses: missing kind=%0d", e.kind);
      end else if (exp_q.size() == 0) begin
        o = obs_q.pop_front(); failures++;
        $display("FAIL exit_pulses: unexpected kind=%0d at cyc %0d", o.kind, o.cyc);
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o.kind !== e.kind) begin
          failures++;
          $display("FAIL exit_pulses: got kind=%0d want kind=%0d", o.kind, e.kind);
        end
      end
    end
  endtask

  task automatic test_simultaneous;
    press(B_UP, 6);
    press(B_MODE, 6);
    press(B_UP | B_DN, 6);
    checks++;
    if (status_o !== 3'd1) begin
      failures++;
      $display("FAIL simul_updown_state: status=%0d want 1", status_o);
    end
    press(B_MODE | B_UP, 6);
    checks++;
    if (status_o !== 3'd2) begin
      failures++;
      $display("FAIL mode_wins_state: status=%0d want 2", status_o);
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL simul_pulses: got %0d pulses (first kind=%0d) want 0", obs_q.size(), obs_q[0].kind);
    end
    obs_q.delete();
  endtask

  task automatic test_auto_repeat;
    ev_t e, o;
    int start;
    @(negedge clock_i);
    start = cyc;
    btn_up_i = 1'b1;
    exp_q.push_back('{3, start + 2 + DEB + 1});
`ifdef AUTO_REPEAT_EN
    // Repeats may fire up to the edge where the debounced release lands (raw held 40 cycles).
    for (int t = 2 + DEB + 1 + HOLD; t <= 40 + 2 + DEB; t += REP) exp_q.push_back('{3, start + t});
`endif
    repeat (40) @(negedge clock_i);
    btn_up_i = 1'b0;
    repeat (30) @(negedge clock_i);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      checks++;
      if (obs_q.size() == 0) begin
        e = exp_q.pop_front(); failures++;
        $display("FAIL repeat_pulses: missing kind=%0d at cyc %0d", e.kind, e.cyc);
      end else if (exp_q.size() == 0) begin
        o = obs_q.pop_front(); failures++;
        $display("FAIL repeat_pulses: unexpected kind=%0d at cyc %0d", o.kind, o.cyc);
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o.kind !== e.kind || o.cyc !== e.cyc) begin
          failures++;
          $display("FAIL repeat_pulses: got kind=%0d cyc=%0d want kind=%0d cyc=%0d", o.kind, o.cyc, e.kind, e.cyc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch_latency();
    test_set_hour();
    test_set_min_exit();
    test_simultaneous();
    test_auto_repeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
